// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared encodings and default latencies for the multiply/divide
//               unit. The start field selects the latency family; the op field
//               selects the arithmetic actually performed.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // Decoder start field
    localparam logic [1:0] START_NONE = 2'b00;
    localparam logic [1:0] START_MULT = 2'b01;
    localparam logic [1:0] START_DIV  = 2'b10;

    // Decoder multdivOP field; bit 0 set means unsigned, bit 1 set means divide
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Default busy periods, in cycles
    localparam int MULT_CYCLES_DEFAULT = 5;
    localparam int DIV_CYCLES_DEFAULT  = 10;

    // Latency counter width; covers the 1..15 latency range
    localparam int CNT_W = 4;

    // Sequencer states, derived from the latency counter
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
// Module      : mdu_arith
// Description : Purely combinational arithmetic core of the multiply/divide
//               unit. Produces the 64-bit product and the 32-bit quotient and
//               remainder for the latched operands, plus a divide-by-zero flag.
// Ports       : i_a, i_b        - operands (dividend/multiplicand, divisor/multiplier)
//               i_op            - multdivOP encoding
//               o_product       - {HI,LO} result for mult/multu
//               o_quotient      - LO result for div/divu
//               o_remainder     - HI result for div/divu
//               o_div_by_zero   - divisor is zero; HI/LO must not be written
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [1:0]  i_op,
    output logic [63:0] o_product,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder,
    output logic        o_div_by_zero
);

    logic        w_signed;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;

    assign w_signed = ~i_op[0];

    // Sign- or zero-extend to 64 bits; the low 64 bits of the extended
    // product are the correct two's-complement result in both cases.
    assign w_a_ext   = {{32{w_signed & i_a[31]}}, i_a};
    assign w_b_ext   = {{32{w_signed & i_b[31]}}, i_b};
    assign o_product = w_a_ext * w_b_ext;

    // Signed division is done on magnitudes. The magnitude of 0x80000000 is
    // representable as an unsigned 32-bit value, so 0x80000000 / -1 yields
    // quotient 0x80000000 after re-negation with no special case.
    assign w_a_neg  = w_signed & i_a[31];
    assign w_b_neg  = w_signed & i_b[31];
    assign w_a_mag  = w_a_neg ? (32'd0 - i_a) : i_a;
    assign w_b_mag  = w_b_neg ? (32'd0 - i_b) : i_b;

    // Keep the divider input non-zero; the result is discarded on zero divisor.
    assign w_b_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_safe;
    assign w_r_mag  = w_a_mag % w_b_safe;

    // Quotient truncates toward zero; remainder takes the dividend's sign.
    assign o_quotient    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign o_remainder   = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
    assign o_div_by_zero = (i_b == 32'd0);

endmodule : mdu_arith
`default_nettype wire

// File: rtl/multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_sequencer
// Description : Fixed-latency multiply/divide sequencer with HI/LO registers
//               for the EX stage. Accepts an operation only when idle, stays
//               busy for the configured latency, then writes HI/LO.
// Ports       : clk, reset       - clock, asynchronous active-low reset
//               start            - 01 mult family, 10 div family (11 ignored)
//               multdivOP        - mult/multu/div/divu
//               A, B             - rs/rt operands
//               HIWrite, LOWrite - mthi/mtlo (A is the source), idle only
//               HILOOP           - read select, 1 = HI, 0 = LO
//               busy             - operation in progress
//               stall_req        - busy or a valid start this cycle
//               hilo_out         - selected HI/LO register, not bypassed
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_sequencer
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  start,
    input  logic [1:0]  multdivOP,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HIWrite,
    input  logic        LOWrite,
    input  logic        HILOOP,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hilo_out
);

    localparam logic [CNT_W-1:0] c_mult_load = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] c_div_load  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [1:0]       r_op;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic [0:0]       w_state;
    logic             w_start_valid;
    logic [63:0]      w_product;
    logic [31:0]      w_quotient;
    logic [31:0]      w_remainder;
    logic             w_div_by_zero;

    // The illegal start encoding 11 behaves exactly like 00.
    assign w_start_valid = (start == START_MULT) || (start == START_DIV);
    assign w_state       = (r_count != '0) ? ST_RUN : ST_IDLE;

    mdu_arith u_arith (
        .i_a           (r_a),
        .i_b           (r_b),
        .i_op          (r_op),
        .o_product     (w_product),
        .o_quotient    (w_quotient),
        .o_remainder   (w_remainder),
        .o_div_by_zero (w_div_by_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (w_state)
                ST_IDLE: begin
                    if (w_start_valid) begin
                        // A start takes priority over a simultaneous mthi/mtlo.
                        r_a     <= A;
                        r_b     <= B;
                        r_op    <= multdivOP;
                        r_count <= (start == START_MULT) ? c_mult_load : c_div_load;
                    end else begin
                        if (HIWrite) r_hi <= A;
                        if (LOWrite) r_lo <= A;
                    end
                end
                ST_RUN: begin
                    // New starts and mthi/mtlo are ignored while running.
                    r_count <= r_count - 1'b1;
                    if (r_count == CNT_W'(1)) begin
                        if (!r_op[1]) begin
                            {r_hi, r_lo} <= w_product;
                        end else if (!w_div_by_zero) begin
                            r_hi <= w_remainder;
                            r_lo <= w_quotient;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (w_state == ST_RUN);
    assign stall_req = busy | w_start_valid;
    assign hilo_out  = HILOOP ? r_hi : r_lo;

endmodule : multdiv_sequencer
`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multdiv_sequencer
// Description : Self-checking bench for multdiv_sequencer. Expected HI/LO
//               pairs are queued when an operation is issued and compared
//               once the unit drops busy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_sequencer;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  start;
    logic [1:0]  multdivOP;
    logic [31:0] A;
    logic [31:0] B;
    logic        HIWrite;
    logic        LOWrite;
    logic        HILOOP;
    logic        busy;
    logic        stall_req;
    logic [31:0] hilo_out;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    multdiv_sequencer #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .multdivOP (multdivOP),
        .A         (A),
        .B         (B),
        .HIWrite   (HIWrite),
        .LOWrite   (LOWrite),
        .HILOOP    (HILOOP),
        .busy      (busy),
        .stall_req (stall_req),
        .hilo_out  (hilo_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference arithmetic on 64-bit integers.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            OP_MULT:  return sa * sb;
            OP_MULTU: return ua * ub;
            OP_DIV: begin
                if (b == 32'd0) return {hi, lo};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {hi, lo};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    task automatic read_hilo(input string tag);
        HILOOP = 1'b1;
        #1 check({tag, "_hi"}, hilo_out, m_hi);
        HILOOP = 1'b0;
        #1 check({tag, "_lo"}, hilo_out, m_lo);
    endtask

    // Issue one operation, measure the busy period, then compare HI/LO.
    task automatic run_op(input string tag, input logic [1:0] st, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int n_exp,
                          input bit with_mthi, input bit poke_mtlo);
        int          n;
        int          stall_bad;
        logic [63:0] exp;
        sb_q.push_back(model(op, a, b, m_hi, m_lo));
        check({tag, "_idle_at_start"}, busy, 1'b0);
        start = st; multdivOP = op; A = a; B = b; HIWrite = with_mthi;
        #1 check({tag, "_stall_start"}, stall_req, 1'b1);
        @(posedge clk); #1;
        start = START_NONE; HIWrite = 1'b0;
        n = 0; stall_bad = 0;
        while (busy && n < 40) begin
            if (!stall_req) stall_bad++;
            if (poke_mtlo && n == 1) begin
                LOWrite = 1'b1; A = 32'hDEADBEEF;
            end else begin
                LOWrite = 1'b0;
            end
            n++;
            @(posedge clk); #1;
        end
        LOWrite = 1'b0;
        check({tag, "_busy_len"}, n, n_exp);
        check({tag, "_stall_busy"}, stall_bad, 0);
        if (sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            {m_hi, m_lo} = exp;
        end
        read_hilo(tag);
        check({tag, "_stall_idle"}, stall_req, 1'b0);
    endtask

    // The hazard unit never presents a start while busy.
    always @(negedge clk) begin
        if (reset && busy && start != START_NONE)
            check("start_while_busy", start, START_NONE);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = START_NONE; multdivOP = OP_MULT;
        A = '0; B = '0; HIWrite = 1'b0; LOWrite = 1'b0; HILOOP = 1'b0;
        #1 check("reset_busy", busy, 1'b0);
        read_hilo("reset");
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;

        run_op("mult",  START_MULT, OP_MULT,  32'hFFFFFFFD, 32'd5, 5, 1'b0, 1'b0);
        run_op("multu", START_MULT, OP_MULTU, 32'hFFFFFFFF, 32'd2, 5, 1'b0, 1'b0);
        run_op("div",   START_DIV,  OP_DIV,   32'hFFFFFFF9, 32'd2, 10, 1'b0, 1'b0);
        // Divide by zero with a simultaneous mthi: both must leave HI/LO alone.
        run_op("divu0", START_DIV,  OP_DIVU,  32'd7, 32'd0, 10, 1'b1, 1'b0);

        // mthi alone, then mthi+mtlo together.
        HIWrite = 1'b1; A = 32'h12345678;
        @(posedge clk); #1;
        HIWrite = 1'b0; m_hi = 32'h12345678;
        read_hilo("mthi");
        HIWrite = 1'b1; LOWrite = 1'b1; A = 32'hCAFEF00D;
        @(posedge clk); #1;
        HIWrite = 1'b0; LOWrite = 1'b0; m_hi = 32'hCAFEF00D; m_lo = 32'hCAFEF00D;
        read_hilo("mthilo");

        // mtlo during busy is dropped.
        run_op("mult_mtlo", START_MULT, OP_MULT, 32'h00010000, 32'h00030000, 5, 1'b0, 1'b1);
        run_op("div_ovf",   START_DIV,  OP_DIV,  32'h80000000, 32'hFFFFFFFF, 10, 1'b0, 1'b0);

        // Back-to-back: second start lands in the cycle busy drops.
        run_op("b2b_mult", START_MULT, OP_MULTU, 32'd1234, 32'd5678, 5, 1'b0, 1'b0);
        run_op("b2b_div",  START_DIV,  OP_DIV,   32'd100, 32'hFFFFFFF9, 10, 1'b0, 1'b0);

        // Asynchronous reset during busy cycle 3 of a divide.
        start = START_DIV; multdivOP = OP_DIVU; A = 32'd1000; B = 32'd3;
        @(posedge clk); #1;
        start = START_NONE;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1 check("abort_busy", busy, 1'b0);
        m_hi = '0; m_lo = '0;
        read_hilo("abort");
        #1 reset = 1'b1;
        @(posedge clk); #1;
        run_op("post_reset", START_MULT, OP_MULT, 32'hFFFFFF00, 32'h00000100, 5, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_multdiv_sequencer
`default_nettype wire

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the P6 five-stage MIPS pipeline.
- Sits in EX and is driven by the decoder's start, multdivOP, HIWrite, LOWrite, HILOOP and Select fields.
- Sequences fixed-latency mult/div operations and reports busy to the hazard unit for stalling.
- Returns HI or LO for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  2  01 = mult family, 10 = div family, 00 = none; 11 illegal, treated as 00.
- multdivOP  in  2  00 mult, 01 multu, 10 div, 11 divu.
- A  in  32  rs operand (dividend / multiplicand).
- B  in  32  rt operand (divisor / multiplier).
- HIWrite  in  1  mthi: HI <= A.
- LOWrite  in  1  mtlo: LO <= A.
- HILOOP  in  1  read select: 1 = HI, 0 = LO.
- busy  out  1  operation in progress (registered).
- stall_req  out  1  combinational busy | (start != 00); to the hazard unit for mfhi/mflo/mthi/mtlo/mult/div stalling.
- hilo_out  out  32  HILOOP ? HI : LO (combinational from the registers).

Behaviour:
- Reset (reset == 0, asynchronous):
  - HI = 0, LO = 0, counter = 0, busy = 0.
  - Operand/op latches = 0.
  - hilo_out therefore reads 0.
- States are IDLE (counter == 0) and RUN (counter != 0). busy = (counter != 0).
- Start in IDLE, start != 00, sampled at edge t0:
  - Latch A, B and multdivOP.
  - Load counter with MULT_CYCLES or DIV_CYCLES according to start.
  - busy is high for exactly N cycles: t0+1 .. t0+N.
- Each RUN edge decrements the counter. On the edge where the counter goes 1 -> 0, HI/LO are written from the latched operands. busy drops and the new HI/LO are visible in the same cycle.
- Result arithmetic:
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: LO = unsigned quotient; HI = unsigned remainder.
  - Divisor == 0: HI and LO keep their prior values, but the full DIV_CYCLES busy period is still consumed.
  - div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Boundary conditions:
  - start while busy: ignored; the counter and latches are not disturbed. The hazard unit must prevent this; the bench asserts it never happens.
  - HIWrite/LOWrite while busy: ignored.
  - HIWrite/LOWrite in IDLE: the write takes effect at that edge. HIWrite and LOWrite together update both registers.
  - start together with HIWrite/LOWrite in IDLE: start wins and the mt write is dropped.
  - Reset asserted mid-operation: the operation is aborted, all state is cleared, and no HI/LO write occurs.
  - Back-to-back ops: a new start is accepted in the cycle busy has dropped. stall_req is low that cycle unless start is presented.
- Reads: hilo_out is not bypassed. A read during busy returns the old value; the hazard unit stalls mfhi/mflo while stall_req is high.

Decomposition:
- Shared package (mdu_pkg):
  - START_NONE/START_MULT/START_DIV encodings.
  - OP_MULT/OP_MULTU/OP_DIV/OP_DIVU encodings.
  - Default latency constants.
- One sub-module, mdu_arith: purely combinational 64-bit product and quotient/remainder from the latched operands and op, including the divide-by-zero flag.
- The sequencer keeps the counter, latches and HI/LO registers.

Test Plan:
- mult A=0xFFFFFFFD (-3), B=5 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1, readable with HILOOP=1 and 0.
- multu A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE; stall_req high in the start cycle and all busy cycles.
- div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 -> 10 busy cycles, HI/LO unchanged.
- mthi A=0x12345678 in IDLE -> HI=0x12345678 next cycle. mtlo issued during a mult busy period -> LO ends as the product, not the mtlo value.
- Reset pulled low at busy cycle 3 of a div -> busy=0 and HI=LO=0 immediately (asynchronous). After release, a new mult completes normally.
- Back-to-back: mult then div started the cycle busy drops -> busy continuous for 5+10 cycles with 1 idle gap; final HI/LO match the div result.
